// File: rtl/mpc_shared_onchip_memory.sv
// Single-port RAM shared by NUM_PORTS Avalon-MM slaves: round-robin grant of one access per cycle, losers see
// waitrequest, reads return READ_LATENCY enabled cycles after grant. `MPC_MEM_STALL_STATS_EN adds per-port stall counters.
module mpc_shared_onchip_memory #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 13,
  parameter int NUM_PORTS    = 4,
  parameter int READ_LATENCY = 1,
  parameter     INIT_FILE    = "mpc_shared_onchip_memory.hex"
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             clken,
  input  logic                             reset_req,
  input  logic [NUM_PORTS-1:0]             chipselect,
  input  logic [NUM_PORTS-1:0]             read,
  input  logic [NUM_PORTS-1:0]             write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  address,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] byteenable,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  writedata,
  output logic [NUM_PORTS-1:0]             waitrequest,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]  readdata,
  output logic [NUM_PORTS-1:0]             readdatavalid
`ifdef MPC_MEM_STALL_STATS_EN
  ,output logic [NUM_PORTS*16-1:0]         stall_count
`endif
);

  localparam int BE    = DATA_WIDTH / 8;
  localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic                  enable;
  logic [NUM_PORTS-1:0]  req;
  logic [NUM_PORTS-1:0]  grant;
  logic [PW-1:0]         ptr;
  logic [PW-1:0]         gidx;
  logic                  gvld;
  logic                  sel_write;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [BE-1:0]         sel_be;
  logic [DATA_WIDTH-1:0] sel_wdata;

  assign enable      = clken & ~reset_req;
  assign req         = chipselect & (read | write);
  assign waitrequest = req & ~grant;

  // First requester at or above ptr, wrapping; a read+write request is treated as a write.
  always_comb begin
    int j;
    j         = 0;
    grant     = '0;
    gidx      = '0;
    gvld      = 1'b0;
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_be    = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_PORTS) j = j - NUM_PORTS;
      if (enable && !gvld && req[j]) begin
        gvld      = 1'b1;
        grant[j]  = 1'b1;
        gidx      = PW'(j);
        sel_write = write[j];
        sel_addr  = address[j*ADDR_WIDTH +: ADDR_WIDTH];
        sel_be    = byteenable[j*BE +: BE];
        sel_wdata = writedata[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] ram_q;

  // RAM contents and its output register are deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (gvld) begin
      if (sel_write) begin
        for (int b = 0; b < BE; b++) begin
          if (sel_be[b]) mem[sel_addr][b*8 +: 8] <= sel_wdata[b*8 +: 8];
        end
      end else begin
        ram_q <= mem[sel_addr];
      end
    end
  end

  logic          q_vld;
  logic [PW-1:0] q_port;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr    <= '0;
      q_vld  <= 1'b0;
      q_port <= '0;
    end else if (enable) begin
      q_vld  <= gvld & ~sel_write;
      q_port <= gidx;
      if (gvld) ptr <= (gidx == PW'(NUM_PORTS - 1)) ? '0 : gidx + PW'(1);
    end
  end

  logic                  f_vld;
  logic [PW-1:0]         f_port;
  logic [DATA_WIDTH-1:0] f_data;

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  p2_vld;
    logic [PW-1:0]         p2_port;
    logic [DATA_WIDTH-1:0] p2_data;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        p2_vld  <= 1'b0;
        p2_port <= '0;
        p2_data <= '0;
      end else if (enable) begin
        p2_vld  <= q_vld;
        p2_port <= q_port;
        p2_data <= ram_q;
      end
    end

    assign f_vld  = p2_vld;
    assign f_port = p2_port;
    assign f_data = p2_data;
  end else begin : g_lat1
    assign f_vld  = q_vld;
    assign f_port = q_port;
    assign f_data = ram_q;
  end

  // Last delivered word per port, so readdata stays stable between strobes.
  logic [DATA_WIDTH-1:0] hold [NUM_PORTS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < NUM_PORTS; p++) hold[p] <= '0;
    end else if (enable && f_vld) begin
      hold[f_port] <= f_data;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_out
    assign readdatavalid[p] = enable & f_vld & (f_port == PW'(p));
    assign readdata[p*DATA_WIDTH +: DATA_WIDTH] = readdatavalid[p] ? f_data : hold[p];
  end

`ifdef MPC_MEM_STALL_STATS_EN
  logic [15:0] stall_cnt [NUM_PORTS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < NUM_PORTS; p++) stall_cnt[p] <= '0;
    end else if (enable) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (waitrequest[p] && stall_cnt[p] != 16'hFFFF) stall_cnt[p] <= stall_cnt[p] + 16'd1;
      end
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_stall
    assign stall_count[p*16 +: 16] = stall_cnt[p];
  end
`endif

endmodule

// File: tb/tb_mpc_shared_onchip_memory.sv
// Directed bench for mpc_shared_onchip_memory (4 ports, 32x8192, READ_LATENCY=1) with a read-return scoreboard.
module tb_mpc_shared_onchip_memory;

  localparam int LAT = 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          clken;
  logic          reset_req;
  logic [3:0]    chipselect;
  logic [3:0]    read;
  logic [3:0]    write;
  logic [51:0]   address;
  logic [15:0]   byteenable;
  logic [127:0]  writedata;
  logic [3:0]    waitrequest;
  logic [127:0]  readdata;
  logic [3:0]    readdatavalid;
`ifdef MPC_MEM_STALL_STATS_EN
  logic [63:0]   stall_count;
`endif

  mpc_shared_onchip_memory #(
    .DATA_WIDTH(32), .ADDR_WIDTH(13), .NUM_PORTS(4), .READ_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req),
    .chipselect(chipselect), .read(read), .write(write), .address(address),
    .byteenable(byteenable), .writedata(writedata), .waitrequest(waitrequest),
    .readdata(readdata), .readdatavalid(readdatavalid)
`ifdef MPC_MEM_STALL_STATS_EN
    , .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          port;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int p, input logic [31:0] d, input int c);
    exp_t e;
    e.port = p;
    e.data = d;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  // Monitor: every return strobe must match the oldest outstanding expected read.
  always @(negedge clk) begin
    if (reset_n) begin
      for (int p = 0; p < 4; p++) begin
        if (readdatavalid[p]) begin
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL rd_unexpected: port=%0d data=%h cyc=%0d with nothing outstanding",
                     p, readdata[p*32 +: 32], cyc);
          end else begin
            exp_t e;
            e = sb.pop_front();
            if (e.port != p || e.data !== readdata[p*32 +: 32] || e.cyc != cyc) begin
              failures++;
              $display("FAIL rd_return: got port=%0d data=%h cyc=%0d expected port=%0d data=%h cyc=%0d",
                       p, readdata[p*32 +: 32], cyc, e.port, e.data, e.cyc);
            end
          end
        end
      end
    end
  end

  // Single-master access; returns just after the grant edge with the request dropped.
  task automatic do_access(input int p, input bit is_wr, input logic [12:0] a,
                           input logic [3:0] b, input logic [31:0] d, input logic [31:0] exp_rd);
    bit granted;
    granted = 1'b0;
    chipselect[p] = 1'b1;
    read[p]       = ~is_wr;
    write[p]      = is_wr;
    address[p*13 +: 13]   = a;
    byteenable[p*4 +: 4]  = b;
    writedata[p*32 +: 32] = d;
    for (int n = 0; n < 50 && !granted; n++) begin
      @(negedge clk);
      if (!waitrequest[p]) begin
        granted = 1'b1;
        if (!is_wr) push_exp(p, exp_rd, cyc + LAT);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (!granted) begin
      failures++;
      $display("FAIL access_timeout: port=%0d never granted, required grant within 50 cycles", p);
    end
    chipselect[p] = 1'b0;
    read[p]       = 1'b0;
    write[p]      = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ew;
    chipselect = '0; read = '0; write = '0; address = '0; byteenable = '0; writedata = '0;
    clken = 1'b1; reset_req = 1'b0; reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_waitrequest", 128'(waitrequest), 128'(0));
    chk("reset_rdv", 128'(readdatavalid), 128'(0));
    chk("reset_readdata", readdata, 128'(0));
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // Byte-lane write then read-back on port 1.
    do_access(1, 1'b1, 13'h010, 4'hF, 32'h0000_0000, 32'h0);
    do_access(1, 1'b1, 13'h010, 4'b0101, 32'hDEAD_BEEF, 32'h0);
    do_access(1, 0, 13'h010, 4'h0, 32'h0, 32'h00AD_00EF);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rdata_hold", 128'(readdata[63:32]), 128'(32'h00AD_00EF));
    @(posedge clk); #1;
    do_access(1, 1'b1, 13'h010, 4'b0000, 32'hFFFF_FFFF, 32'h0);
    do_access(1, 0, 13'h010, 4'h0, 32'h0, 32'h00AD_00EF);

    for (int i = 0; i < 4; i++)
      do_access(3, 1'b1, 13'h100 + 13'(i), 4'hF, 32'hA0A0_0000 | 32'(i), 32'h0);

    // Simultaneous write (port 2) and read (port 3) of the top word, ptr=0.
    chipselect[2] = 1'b1; write[2] = 1'b1; address[26 +: 13] = 13'h1FFF;
    byteenable[8 +: 4] = 4'hF; writedata[64 +: 32] = 32'h1234_5678;
    chipselect[3] = 1'b1; read[3] = 1'b1; address[39 +: 13] = 13'h1FFF;
    @(negedge clk);
    chk("t4_first_grant", 128'(waitrequest), 128'(4'b1000));
    @(posedge clk); #1 chipselect[2] = 1'b0; write[2] = 1'b0;
    @(negedge clk);
    chk("t4_second_grant", 128'(waitrequest), 128'(0));
    push_exp(3, 32'h1234_5678, cyc + LAT);
    @(posedge clk); #1 chipselect[3] = 1'b0; read[3] = 1'b0;

    // Read held across 3 clken=0 cycles while port 1 waits.
    chipselect[0] = 1'b1; read[0] = 1'b1; address[0 +: 13] = 13'h010;
    @(negedge clk);
    chk("t5_clken_grant", 128'(waitrequest), 128'(0));
    push_exp(0, 32'h00AD_00EF, cyc + LAT + 3);
    @(posedge clk); #1;
    chipselect[0] = 1'b0; read[0] = 1'b0; clken = 1'b0;
    chipselect[1] = 1'b1; read[1] = 1'b1; address[13 +: 13] = 13'h101;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_clken_wait", 128'(waitrequest), 128'(4'b0010));
      chk("t5_clken_rdv", 128'(readdatavalid), 128'(0));
      @(posedge clk); #1;
    end
    clken = 1'b1;
    @(negedge clk);
    chk("t5_clken_p1_grant", 128'(waitrequest), 128'(0));
    push_exp(1, 32'hA0A0_0001, cyc + LAT);
    @(posedge clk); #1 chipselect[1] = 1'b0; read[1] = 1'b0;

    // Same hold-off through reset_req.
    chipselect[0] = 1'b1; read[0] = 1'b1; address[0 +: 13] = 13'h1FFF;
    @(negedge clk);
    chk("t5_rreq_grant", 128'(waitrequest), 128'(0));
    push_exp(0, 32'h1234_5678, cyc + LAT + 3);
    @(posedge clk); #1;
    chipselect[0] = 1'b0; read[0] = 1'b0; reset_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_rreq_rdv", 128'(readdatavalid), 128'(0));
      @(posedge clk); #1;
    end
    reset_req = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Reset with a read in flight on port 0.
    chipselect[0] = 1'b1; read[0] = 1'b1; address[0 +: 13] = 13'h100;
    @(negedge clk);
    chk("t1_grant", 128'(waitrequest), 128'(0));
    @(posedge clk); #1;
    chipselect[0] = 1'b0; read[0] = 1'b0; clken = 1'b0;
    @(negedge clk);
    chk("t1_held_rdv", 128'(readdatavalid), 128'(0));
    #1 reset_n = 1'b0;
    #1;
    chk("t1_reset_rdata", readdata, 128'(0));
    chk("t1_reset_rdv", 128'(readdatavalid), 128'(0));
    chk("t1_reset_waitrequest", 128'(waitrequest), 128'(0));
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1; clken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t1_no_rdv_after_release", 128'(readdatavalid), 128'(0));
    end
    @(posedge clk); #1;

    // All four ports reading continuously: rotation must start at port 0.
    for (int p = 0; p < 4; p++) begin
      chipselect[p] = 1'b1; read[p] = 1'b1; address[p*13 +: 13] = 13'h100 + 13'(p);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ew = 4'hF & ~(4'b0001 << (i % 4));
      chk("t3_rr_waitrequest", 128'(waitrequest), 128'(ew));
      push_exp(i % 4, 32'hA0A0_0000 | 32'(i % 4), cyc + LAT);
      @(posedge clk); #1;
    end
    chipselect = '0; read = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sb_drained", 128'(sb.size()), 128'(0));

`ifdef MPC_MEM_STALL_STATS_EN
    @(posedge clk); #1;
    for (int p = 0; p < 4; p++) begin
      chipselect[p] = 1'b1; write[p] = 1'b1; address[p*13 +: 13] = 13'h200 + 13'(p);
      byteenable[p*4 +: 4] = 4'hF;
    end
    repeat (88000) @(posedge clk);
    @(negedge clk);
    chk("t6_stall_sat_p0", 128'(stall_count[15:0]), 128'(16'hFFFF));
    chk("t6_stall_sat_p3", 128'(stall_count[63:48]), 128'(16'hFFFF));
    chipselect = '0; write = '0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
